// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs a 32-bit immediate into a RISC-V instruction skeleton, expands LI into LUI+ADDI
// Optional IMM_ENC_RANGE_CHECK_EN: flag immediates that do not fit the selected format.
module imm_encoder #(
  parameter logic [31:0] RESET_INSN = 32'h0000_0013,
  parameter int          LI_SHORT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] base_insn,
  input  logic [31:0] imm,
  input  logic [2:0]  imm_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] insn,
  output logic        last,
  output logic        range_err
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ONE  = 2'b01;
  localparam logic [1:0] HI   = 2'b10;

  logic [1:0]  state;
  logic [31:0] addi_q;
  logic        accept;

  logic [31:0] enc_insn;
  logic [31:0] enc_addi;
  logic        enc_err;
  logic        enc_last;
  logic        enc_two;

  logic [4:0]  rd;
  logic [19:0] li_hi;
  logic        li_fits;
  logic        err_is;
  logic        err_b;
  logic        err_j;
  logic        err_u;

  assign rd       = base_insn[11:7];
  // LUI upper part is pre-incremented so the sign-extended ADDI low part lands back on imm
  assign li_hi    = imm[31:12] + {19'd0, imm[11]};
  assign li_fits  = (&imm[31:11]) || !(|imm[31:11]);
  assign enc_addi = {imm[11:0], rd, 3'b000, rd, 7'b0010011};

`ifdef IMM_ENC_RANGE_CHECK_EN
  assign err_is = !li_fits;
  assign err_b  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
  assign err_j  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
  assign err_u  = |imm[11:0];
`else
  assign err_is = 1'b0;
  assign err_b  = 1'b0;
  assign err_j  = 1'b0;
  assign err_u  = 1'b0;
`endif

  always_comb begin
    enc_insn = base_insn;
    enc_err  = 1'b0;
    enc_last = 1'b1;
    enc_two  = 1'b0;
    case (imm_src)
      3'b000: begin
        enc_insn = {imm[11:0], base_insn[19:0]};
        enc_err  = err_is;
      end
      3'b001: begin
        enc_insn = {imm[11:5], base_insn[24:12], imm[4:0], base_insn[6:0]};
        enc_err  = err_is;
      end
      3'b010: begin
        enc_insn = {imm[12], imm[10:5], base_insn[24:12], imm[4:1], imm[11], base_insn[6:0]};
        enc_err  = err_b;
      end
      3'b011: begin
        enc_insn = {imm[20], imm[10:1], imm[11], imm[19:12], base_insn[11:0]};
        enc_err  = err_j;
      end
      3'b100: begin
        enc_insn = {imm[31:12], base_insn[11:0]};
        enc_err  = err_u;
      end
      3'b101: begin
        if (LI_SHORT != 0 && li_fits) begin
          enc_insn = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
        end else begin
          enc_insn = {li_hi, rd, 7'b0110111};
          enc_last = 1'b0;
          enc_two  = 1'b1;
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign out_valid = (state != IDLE);
  assign in_ready  = (state == IDLE) || (state == ONE && out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      insn      <= RESET_INSN;
      last      <= 1'b0;
      range_err <= 1'b0;
      addi_q    <= '0;
    end else if (accept) begin
      insn      <= enc_insn;
      last      <= enc_last;
      range_err <= enc_err;
      addi_q    <= enc_addi;
      state     <= enc_two ? HI : ONE;
    end else if (state == HI && out_ready) begin
      insn      <= addi_q;
      last      <= 1'b1;
      range_err <= 1'b0;
      state     <= ONE;
    end else if (state == ONE && out_ready) begin
      state     <= IDLE;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder against a behavioural encoder model
module tb_imm_encoder;

  localparam int LI_SHORT = 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base_insn;
  logic [31:0] imm;
  logic [2:0]  imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] insn;
  logic        last;
  logic        range_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] w;
    logic        l;
    logic        e;
  } beat_t;

  imm_encoder #(.RESET_INSN(32'h0000_0013), .LI_SHORT(LI_SHORT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .base_insn(base_insn), .imm(imm), .imm_src(imm_src),
    .out_valid(out_valid), .out_ready(out_ready), .insn(insn),
    .last(last), .range_err(range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic outside(input logic [31:0] v, input longint lo, input longint hi);
    longint s;
    s = longint'($signed(v));
    return (s < lo) || (s > hi);
  endfunction

  // Reference: list of beats a request produces, computed from the field rules
  function automatic void model(input logic [31:0] b, input logic [31:0] v, input logic [2:0] src,
                                output int n, output beat_t bt0, output beat_t bt1);
    logic        e;
    logic [19:0] hi;
    logic [4:0]  r;
    e = 1'b0;
    n = 1;
    r = b[11:7];
    bt1 = '0;
    bt0 = '{w: b, l: 1'b1, e: 1'b0};
    case (src)
      3'd0: begin bt0.w = {v[11:0], b[19:0]}; e = outside(v, -2048, 2047); end
      3'd1: begin bt0.w = {v[11:5], b[24:12], v[4:0], b[6:0]}; e = outside(v, -2048, 2047); end
      3'd2: begin
        bt0.w = {v[12], v[10:5], b[24:12], v[4:1], v[11], b[6:0]};
        e = outside(v, -4096, 4094) || (v % 2 != 0);
      end
      3'd3: begin
        bt0.w = {v[20], v[10:1], v[11], v[19:12], b[11:0]};
        e = outside(v, -1048576, 1048574) || (v % 2 != 0);
      end
      3'd4: begin bt0.w = {v[31:12], b[11:0]}; e = (v % 4096 != 0); end
      3'd5: begin
        if (LI_SHORT == 1 && !outside(v, -2048, 2047)) begin
          bt0.w = {v[11:0], 5'd0, 3'b000, r, 7'b0010011};
        end else begin
          hi = 20'((v >> 12) + ((v >> 11) & 1));
          bt0 = '{w: {hi, r, 7'b0110111}, l: 1'b0, e: 1'b0};
          bt1 = '{w: {v[11:0], r, 3'b000, r, 7'b0010011}, l: 1'b1, e: 1'b0};
          n = 2;
        end
      end
      default: begin bt0.w = b; end
    endcase
`ifdef IMM_ENC_RANGE_CHECK_EN
    if (src <= 3'd4) bt0.e = e;
`endif
    if (src > 3'd5) bt0.e = 1'b1;
  endfunction

  function automatic logic [31:0] pick_imm();
    logic [31:0] edges [12];
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
              -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576, 32'h12345000};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return edges[$urandom_range(0, 11)];
      default: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
  endfunction

  task automatic drive_req(input logic [31:0] b, input logic [31:0] v, input logic [2:0] s);
    @(negedge clk);
    base_insn = b; imm = v; imm_src = s; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; base_insn = '0; imm = '0; imm_src = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || insn !== 32'h13 || last !== 1'b0 || range_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b insn=%h last=%b err=%b rdy=%b required 0 00000013 0 0 1",
               out_valid, insn, last, range_err, in_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_itype();
    out_ready = 1'b1;
    drive_req(32'h93, 32'hFFFF_FFFF, 3'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || insn !== 32'hFFF00093 || last !== 1'b1 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL itype: valid=%b insn=%h last=%b err=%b required 1 fff00093 1 0", out_valid, insn, last, range_err);
    end
  endtask

  task automatic test_btype();
    logic exp_e;
    drive_req(32'h63, 32'd8, 3'd2);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || insn !== 32'h463 || range_err !== 1'b0) begin
      errors++; $display("FAIL btype_even: insn=%h err=%b required 00000463 0", insn, range_err);
    end
    drive_req(32'h63, 32'd7, 3'd2);
    @(negedge clk);
`ifdef IMM_ENC_RANGE_CHECK_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    checks++;
    if (out_valid !== 1'b1 || range_err !== exp_e) begin
      errors++; $display("FAIL btype_odd: err=%b required %b", range_err, exp_e);
    end
    drive_req(32'h1234_5678, 32'd0, 3'd6);
    @(negedge clk);
    checks++;
    if (insn !== 32'h1234_5678 || range_err !== 1'b1 || last !== 1'b1) begin
      errors++; $display("FAIL reserved: insn=%h err=%b last=%b required 12345678 1 1", insn, range_err, last);
    end
  endtask

  task automatic test_li_split();
    drive_req(32'h280, 32'h12345FFF, 3'd5);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || insn !== 32'h123462B7 || last !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL li_beat1: insn=%h last=%b rdy=%b required 123462b7 0 0", insn, last, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || insn !== 32'hFFF28293 || last !== 1'b1 || range_err !== 1'b0) begin
      errors++; $display("FAIL li_beat2: insn=%h last=%b required fff28293 1", insn, last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL li_done: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_li_short();
    drive_req(32'h280, 32'h7FF, 3'd5);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || insn !== 32'h7FF00293 || last !== 1'b1) begin
      errors++; $display("FAIL li_short: insn=%h last=%b required 7ff00293 1", insn, last);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL li_short_done: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_req(32'h280, 32'h12345FFF, 3'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; imm_src = 3'd0;
      checks++;
      if (out_valid !== 1'b1 || insn !== 32'h123462B7 || last !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hi[%0d]: insn=%h last=%b rdy=%b required 123462b7 0 0", k, insn, last, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || insn !== 32'hFFF28293 || last !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_one[%0d]: insn=%h last=%b rdy=%b required fff28293 1 0", k, insn, last, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [5];
    logic [31:0] v;
    out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 || insn !== exp_w[k-1] || last !== 1'b1) begin
          errors++; $display("FAIL b2b[%0d]: valid=%b insn=%h required 1 %h", k - 1, out_valid, insn, exp_w[k-1]);
        end
      end
      if (k < 5) begin
        v = 32'($urandom_range(0, 4095)) - 32'd2048;
        base_insn = 32'h00000513; imm = v; imm_src = 3'd0; in_valid = 1'b1;
        exp_w[k] = {v[11:0], 20'h00513};
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", k, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_req(32'h280, 32'h12345FFF, 3'd5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || insn !== 32'h13 || last !== 1'b0) begin
      errors++; $display("FAIL reset_mid: valid=%b insn=%h last=%b required 0 00000013 0", out_valid, insn, last);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    drive_req(32'h93, 32'd5, 3'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || insn !== 32'h00500093 || last !== 1'b1) begin
      errors++; $display("FAIL post_reset: insn=%h last=%b required 00500093 1", insn, last);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stale_addi[%0d]: out_valid=%b insn=%h required 0", k, out_valid, insn);
      end
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b0, b1;
    int    n;
    logic  exp_rdy;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      base_insn = $urandom;
      imm       = pick_imm();
      imm_src   = 3'($urandom_range(0, 7));
      #1;
      exp_rdy = (q.size() == 0) || (out_ready && q[0].l);
      checks++;
      if (in_ready !== exp_rdy || out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_hs[%0d]: rdy=%b valid=%b required %b %b", cyc, in_ready, out_valid, exp_rdy, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (insn !== q[0].w || last !== q[0].l || range_err !== q[0].e) begin
          errors++;
          $display("FAIL rnd_beat[%0d]: insn=%h last=%b err=%b required %h %b %b",
                   cyc, insn, last, range_err, q[0].w, q[0].l, q[0].e);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        model(base_insn, imm, imm_src, n, b0, b1);
        q.push_back(b0);
        if (n == 2) q.push_back(b1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() != 0; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || insn !== q[0].w || last !== q[0].l || range_err !== q[0].e) begin
        errors++; $display("FAIL rnd_drain: insn=%h last=%b required %h %b", insn, last, q[0].w, q[0].l);
      end
      void'(q.pop_front());
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rnd_end: pending=%0d out_valid=%b required 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_btype();
    test_li_split();
    test_li_short();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
